// File: rtl/ext_pkg.sv
// Shared definitions for the result-extension FIFO.
// Latency: n/a (types, constants and a constant function only).
// Backpressure: n/a.
//
// Contents:
//   EXT_ZERO / EXT_SIGN : encodings of the per-transaction extension mode
//   ext_mode_t          : 1-bit extension mode type
//   ptr_w(depth)        : pointer width for a power-of-two FIFO depth
package ext_pkg;

    localparam logic EXT_ZERO = 1'b0;
    localparam logic EXT_SIGN = 1'b1;

    typedef logic ext_mode_t;

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/ext_unit.sv
// Zero/sign extender from IN_W to OUT_W bits.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
//
// Ports:
//   i_data : raw IN_W-bit result
//   i_sext : extension mode (EXT_SIGN replicates i_data MSB, EXT_ZERO fills zeros)
//   o_word : OUT_W-bit extended word
module ext_unit
    import ext_pkg::*;
#(
    parameter int IN_W  = 1,
    parameter int OUT_W = 32
) (
    input  logic [IN_W-1:0]  i_data,
    input  ext_mode_t        i_sext,
    output logic [OUT_W-1:0] o_word
);

    generate
        if (IN_W == OUT_W) begin : g_pass
            // Nothing to extend; the mode input has no effect at equal widths.
            assign o_word = i_data;
        end else begin : g_ext
            logic w_fill;

            always_comb begin
                w_fill = 1'b0;
                case (i_sext)
                    EXT_SIGN: w_fill = i_data[IN_W-1];
                    EXT_ZERO: w_fill = 1'b0;
                    default:  w_fill = 1'b0;
                endcase
            end

            assign o_word = {{(OUT_W-IN_W){w_fill}}, i_data};
        end
    endgenerate

endmodule

// File: rtl/ext_fifo_buffer.sv
// Extends IN_W-bit results to OUT_W bits at push time and queues them in a DEPTH-entry FIFO.
// Latency: a word pushed in cycle N is visible on out_data/out_valid in cycle N+1.
// Backpressure: in_ready drops when full (no pass-through); head held stable until out_ready.
//
// Ports:
//   clk, rst            : single clock, synchronous active-high reset
//   in_valid/in_ready   : producer handshake; in_data + in_sext sampled on push
//   out_valid/out_ready : consumer handshake; out_data is the extended head word (0 when empty)
//   count               : occupancy 0..DEPTH
//   xfer_cnt            : 16-bit wrapping pop counter, present only when EXT_STATS_EN is defined
module ext_fifo_buffer
    import ext_pkg::*;
#(
    parameter int IN_W  = 1,
    parameter int OUT_W = 32,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [IN_W-1:0]         in_data,
    input  ext_mode_t               in_sext,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [OUT_W-1:0]        out_data,
`ifdef EXT_STATS_EN
    output logic [15:0]             xfer_cnt,
`endif
    output logic [ptr_w(DEPTH):0]   count
);

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = PW + 1;

    logic [OUT_W-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic [OUT_W-1:0] w_ext_word;
    logic             w_push;
    logic             w_pop;

    ext_unit #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_ext (
        .i_data (in_data),
        .i_sext (in_sext),
        .o_word (w_ext_word)
    );

    // Both flags come from registered occupancy only, so a pop never opens
    // a slot for a push in the same cycle.
    assign in_ready  = (r_count != CW'(DEPTH));
    assign out_valid = (r_count != '0);
    assign out_data  = out_valid ? r_mem[r_rd_ptr] : '0;
    assign count     = r_count;

    assign w_push = in_valid & in_ready;
    assign w_pop  = out_valid & out_ready;

    // Storage is deliberately not reset; stale entries are unreachable once
    // the pointers and occupancy are cleared.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_ext_word;
        end
    end

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef EXT_STATS_EN
    logic [15:0] r_xfer_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_xfer_cnt <= '0;
        end else if (w_pop) begin
            r_xfer_cnt <= r_xfer_cnt + 1'b1;
        end
    end

    assign xfer_cnt = r_xfer_cnt;
`endif

endmodule

// File: tb/tb_ext_fifo_buffer.sv
// Directed bench for ext_fifo_buffer: IN_W=8 main instance plus an IN_W=1 instance.
// Inputs are driven and outputs checked 1 time unit after each rising edge.
module tb_ext_fifo_buffer;

    logic        clk = 1'b0;
    logic        rst;

    // Main instance: IN_W=8, OUT_W=32, DEPTH=4
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        in_sext;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [2:0]  count;

    // Narrow instance: IN_W=1, OUT_W=32, DEPTH=4
    logic        d1_in_valid;
    logic        d1_in_ready;
    logic [0:0]  d1_in_data;
    logic        d1_in_sext;
    logic        d1_out_valid;
    logic        d1_out_ready;
    logic [31:0] d1_out_data;
    logic [2:0]  d1_count;

`ifdef EXT_STATS_EN
    logic [15:0] xfer_cnt;
    logic [15:0] d1_xfer_cnt;
`endif

    int          tests = 0;
    int          fails = 0;
    logic [31:0] q[$];
    logic [15:0] m_pops;

    always #5 clk = ~clk;

    ext_fifo_buffer #(.IN_W(8), .OUT_W(32), .DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sext   (in_sext),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
`ifdef EXT_STATS_EN
        .xfer_cnt  (xfer_cnt),
`endif
        .count     (count)
    );

    ext_fifo_buffer #(.IN_W(1), .OUT_W(32), .DEPTH(4)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (d1_in_valid),
        .in_ready  (d1_in_ready),
        .in_data   (d1_in_data),
        .in_sext   (d1_in_sext),
        .out_valid (d1_out_valid),
        .out_ready (d1_out_ready),
        .out_data  (d1_out_data),
`ifdef EXT_STATS_EN
        .xfer_cnt  (d1_xfer_cnt),
`endif
        .count     (d1_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ext8(input logic [7:0] d, input logic s);
        return s ? {{24{d[7]}}, d} : {24'h0, d};
    endfunction

    task automatic check_state();
        logic [31:0] exp_data;
        exp_data = (q.size() != 0) ? q[0] : 32'h0;
        chk("in_ready",  {31'b0, in_ready},  {31'b0, (q.size() != 4)});
        chk("out_valid", {31'b0, out_valid}, {31'b0, (q.size() != 0)});
        chk("out_data",  out_data, exp_data);
        chk("count",     {29'b0, count}, 32'(q.size()));
`ifdef EXT_STATS_EN
        chk("xfer_cnt",  {16'b0, xfer_cnt}, {16'b0, m_pops});
`endif
    endtask

    // One clock of the main instance; called 1 unit after a rising edge.
    task automatic step(input logic iv, input logic [7:0] d, input logic s, input logic ordy);
        logic push;
        logic pop;
        in_valid  = iv;
        in_data   = d;
        in_sext   = s;
        out_ready = ordy;
        push = iv && (q.size() != 4);
        pop  = ordy && (q.size() != 0);
        @(posedge clk);
        #1;
        if (pop) begin
            void'(q.pop_front());
            m_pops = m_pops + 16'd1;
        end
        if (push) begin
            q.push_back(ext8(d, s));
        end
        check_state();
    endtask

    // Reset for one edge; inputs are left as the caller set them.
    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        m_pops = 16'd0;
        check_state();
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        in_valid     = 1'b0;
        in_data      = 8'h00;
        in_sext      = 1'b0;
        out_ready    = 1'b0;
        d1_in_valid  = 1'b0;
        d1_in_data   = 1'b0;
        d1_in_sext   = 1'b0;
        d1_out_ready = 1'b0;
        m_pops       = 16'd0;

        // Reset state
        do_reset();
        chk("rst_count",     {29'b0, count}, 32'd0);
        chk("rst_in_ready",  {31'b0, in_ready}, 32'd1);
        chk("d1_rst_valid",  {31'b0, d1_out_valid}, 32'd0);
        chk("d1_rst_data",   d1_out_data, 32'h0);

        // Narrow instance: 1'b1 zero-extended, one-cycle latency
        d1_in_valid = 1'b1;
        d1_in_data  = 1'b1;
        d1_in_sext  = 1'b0;
        // Main instance: 8'h80 sign-extended
        step(1'b1, 8'h80, 1'b1, 1'b0);
        chk("d1_zext_data",  d1_out_data, 32'h0000_0001);
        chk("d1_zext_valid", {31'b0, d1_out_valid}, 32'd1);
        chk("sext80",        out_data, 32'hFFFF_FF80);
        chk("sext80_count",  {29'b0, count}, 32'd1);

        // Narrow: push sign-extended 1 while popping the head
        d1_in_sext   = 1'b1;
        d1_out_ready = 1'b1;
        step(1'b1, 8'h80, 1'b0, 1'b0);   // main: 8'h80 zero-extended
        chk("d1_sext_data",  d1_out_data, 32'hFFFF_FFFF);
        chk("d1_sext_count", {29'b0, d1_count}, 32'd1);
        d1_in_valid = 1'b0;
        step(1'b1, 8'h7F, 1'b1, 1'b0);
        chk("d1_empty_data", d1_out_data, 32'h0);
        chk("d1_empty_vld",  {31'b0, d1_out_valid}, 32'd0);
        d1_out_ready = 1'b0;

        // Fill to DEPTH
        step(1'b1, 8'h01, 1'b0, 1'b0);
        chk("full_count",    {29'b0, count}, 32'd4);
        chk("full_in_ready", {31'b0, in_ready}, 32'd0);
        chk("head_in_order", out_data, 32'hFFFF_FF80);

        // 5th word while full is dropped
        step(1'b1, 8'hAA, 1'b1, 1'b0);
        chk("drop_count",    {29'b0, count}, 32'd4);

        // Full with simultaneous push/pop attempt: pop only
        step(1'b1, 8'h55, 1'b0, 1'b1);
        chk("fullpp_count",  {29'b0, count}, 32'd3);
        chk("fullpp_head",   out_data, 32'h0000_0080);
        step(1'b1, 8'h55, 1'b0, 1'b0);
        chk("fullpp_accept", {29'b0, count}, 32'd4);

        // Head held stable under backpressure
        step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("hold_data",     out_data, 32'h0000_0080);

        // Drain in order
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("drain1",        out_data, 32'h0000_007F);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("drain2",        out_data, 32'h0000_0001);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("drain3",        out_data, 32'h0000_0055);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("drain_empty",   out_data, 32'h0);
        chk("drain_count",   {29'b0, count}, 32'd0);

        // Empty: push with out_ready high is not popped in the same cycle
        step(1'b1, 8'hC3, 1'b1, 1'b1);
        chk("empty_pp_cnt",  {29'b0, count}, 32'd1);
        chk("empty_pp_data", out_data, 32'hFFFF_FFC3);
        step(1'b0, 8'h00, 1'b0, 1'b1);

        // Random traffic with pointer wrap, checked against the queue model
        for (int i = 0; i < 2000; i++) begin
            step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)));
        end

        // Mid-stream reset with three queued words
        step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b1, 8'h11, 1'b0, 1'b0);
        step(1'b1, 8'h22, 1'b0, 1'b0);
        step(1'b1, 8'h33, 1'b0, 1'b0);
        chk("pre_rst_count", {29'b0, count}, 32'd3);
        in_valid = 1'b1;
        do_reset();
        chk("mid_rst_count", {29'b0, count}, 32'd0);
        chk("mid_rst_valid", {31'b0, out_valid}, 32'd0);
        chk("mid_rst_data",  out_data, 32'h0);
        chk("mid_rst_ready", {31'b0, in_ready}, 32'd1);
`ifdef EXT_STATS_EN
        chk("rst_xfer",      {16'b0, xfer_cnt}, 32'h0);
`endif

`ifdef EXT_STATS_EN
        // Stream at one pop per cycle until the pop counter reaches 0xFFFF, then wrap
        begin
            int guard;
            guard = 0;
            while (m_pops != 16'hFFFF && guard < 70000) begin
                step(1'b1, 8'($urandom), 1'b0, 1'b1);
                guard++;
            end
            chk("xfer_ffff", {16'b0, xfer_cnt}, 32'h0000_FFFF);
            step(1'b1, 8'h00, 1'b0, 1'b1);
            chk("xfer_wrap", {16'b0, xfer_cnt}, 32'h0);
            in_valid = 1'b0;
            do_reset();
            chk("xfer_rst",  {16'b0, xfer_cnt}, 32'h0);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
